usb_crc_serial: RTL and testbench
=================================

Name: usb_crc_serial

Overview:
- Parametrised serial CRC engine for the USB packet path; successor to the fixed 16-bit serial CRC.
- One instance serves CRC5 (tokens) or CRC16 (data) by parameter.
- Two modes, selected per packet:
  - Generate: accumulates payload bits, then shifts out the complemented remainder MSB-first.
  - Check: accumulates payload plus received CRC, then compares the register with the residual.
- Sits between the bit-stuffer/unstuffer and the NRZI stage; honours stall cycles from stuffing.

Parameters:
- WIDTH, 16: CRC register width; 5 or 16 are the supported values.
- POLY, 16'h8005: generator polynomial without the x^WIDTH term; WIDTH bits used. Use 5'h05 for CRC5.
- INIT, all ones: register preload on start.
- RESIDUAL, 16'h800D: expected register value after a correct payload plus CRC. Use 5'h0C for CRC5.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- crc_start  in  1  single-cycle pulse; preload INIT and begin a packet
- crc_mode  in  1  0 = generate, 1 = check; sampled on crc_start
- bit_valid  in  1  s_in is a payload bit this cycle; low = stall
- s_in  in  1  serial payload bit, in wire order
- crc_eop  in  1  single-cycle pulse; last payload bit has been given
- crc_ready  out  1  engine idle, can take crc_start
- crc_out  out  1  serial CRC bit, generate mode only
- crc_out_valid  out  1  crc_out is valid this cycle
- crc_out_stall  in  1  hold crc_out this cycle (stuffing); valid stays high
- crc_done  out  1  single-cycle completion pulse
- crc_ok  out  1  check result; valid while crc_done is high and held until the next crc_start
- crc_val  out  WIDTH  remainder latched at eop (see optional feature)

Behaviour:
- Reset (rst high at a clk edge, any state):
  - State goes to IDLE; CRC register takes INIT.
  - crc_ready=1; crc_out, crc_out_valid, crc_done, crc_ok=0; crc_val=0.
  - Reset mid-packet abandons the packet with no crc_done.
- Register update, on each cycle in CALC with bit_valid=1:
  - fb = s_in ^ crc[WIDTH-1]
  - crc <= {crc[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)
- States:
  - IDLE: crc_ready=1. On crc_start, register takes INIT, mode is latched, go to CALC.
  - CALC: updates on bit_valid. On crc_eop:
    - If bit_valid is also high that cycle, that bit is included.
    - Generate mode: snapshot ~crc_next into the shift register, go to SEND.
    - Check mode: crc_ok <= (crc_next == RESIDUAL), go to DONE.
  - SEND: crc_out = shift[WIDTH-1], crc_out_valid=1.
    - Shifts left each cycle unless crc_out_stall=1.
    - A down-counter of WIDTH tracks emitted bits; after the WIDTH-th accepted bit, go to DONE.
    - Latency: first CRC bit is valid the cycle after eop.
  - DONE: crc_done=1 for exactly one cycle, then IDLE.
- crc_start outside IDLE:
  - In CALC or SEND: restart — register takes INIT, mode is re-latched, go to CALC, no crc_done.
  - In DONE: crc_done still pulses, and the start is taken as in IDLE in the same cycle (back-to-back packets).
- crc_start and crc_eop in the same cycle: start wins and eop is ignored.
- crc_eop outside CALC is ignored.
- bit_valid outside CALC is ignored.
- Zero-length payload (eop the cycle after start): generate mode emits ~INIT, i.e. all zeros.
- Only the low WIDTH bits of POLY, INIT and RESIDUAL are used.

Optional Feature:
- Macro: USB_CRC_PARALLEL_VAL_EN
- Defined:
  - crc_val takes the pre-complement remainder at eop.
  - crc_val is held until the next crc_start or rst.
- Undefined:
  - crc_val is tied to 0 and no latch register is built.
  - All other behaviour is identical.

Test Plan:
- CRC16 generate, zero-length: start, eop next cycle -> 16 crc_out bits all 0, crc_out_valid high for 16 cycles, one crc_done pulse.
- CRC5 (WIDTH=5, POLY=5'h05, INIT=5'h1F), generate, one payload bit 0:
  - Required register value 5'h1B.
  - crc_out sequence 0,0,1,0,0.
  - crc_val=5'h1B when the macro is defined.
- CRC16 check round-trip:
  - Payload bytes 0xD5,0x00 in wire order, followed by the CRC that generate mode emits for them -> crc_ok=1.
  - Same stream with one payload bit flipped -> crc_ok=0.
- Stalls:
  - bit_valid low for 3 cycles mid-payload -> same CRC as with no stalls.
  - crc_out_stall high for 2 SEND cycles -> crc_out held; total valid cycles = WIDTH+2; sequence unchanged.
- Restart/reset:
  - crc_start during SEND -> no crc_done; the new packet's CRC matches a clean run.
  - rst mid-CALC -> crc_ready=1 and all outputs 0 next cycle.
- Back-to-back: crc_start in the DONE cycle -> crc_done pulse seen, and the second packet's CRC is correct.

Source files
------------

// File: rtl/usb_crc_serial_if.sv
// usb_crc_serial_if: groups the packet-side handshake and the serial CRC
// output of the USB serial CRC engine. WIDTH sizes the parallel crc_val bus.
// The master modport is the packet path driving the engine; the slave
// modport is the engine itself.
interface usb_crc_serial_if #(
   parameter int WIDTH = 16
) ();
   logic             crc_start;
   logic             crc_mode;
   logic             bit_valid;
   logic             s_in;
   logic             crc_eop;
   logic             crc_ready;
   logic             crc_out;
   logic             crc_out_valid;
   logic             crc_out_stall;
   logic             crc_done;
   logic             crc_ok;
   logic [WIDTH-1:0] crc_val;

   modport master (
      output crc_start, crc_mode, bit_valid, s_in, crc_eop, crc_out_stall,
      input  crc_ready, crc_out, crc_out_valid, crc_done, crc_ok, crc_val
   );

   modport slave (
      input  crc_start, crc_mode, bit_valid, s_in, crc_eop, crc_out_stall,
      output crc_ready, crc_out, crc_out_valid, crc_done, crc_ok, crc_val
   );
endinterface

// File: rtl/usb_crc_serial.sv
// usb_crc_serial: parametrised serial CRC engine for the USB packet path.
// WIDTH=16/POLY=16'h8005/RESIDUAL=16'h800D gives the data CRC16; WIDTH=5 with
// POLY=5'h05/INIT=5'h1F/RESIDUAL=5'h0C gives the token CRC5. Generate mode
// shifts out the complemented remainder MSB-first; check mode compares the
// final register with the residual.
// Optional: define USB_CRC_PARALLEL_VAL_EN to latch the pre-complement
// remainder on crc_val at eop; otherwise crc_val is tied to zero.
module usb_crc_serial #(
   parameter int          WIDTH    = 16,
   parameter logic [15:0] POLY     = 16'h8005,
   parameter logic [15:0] INIT     = 16'hFFFF,
   parameter logic [15:0] RESIDUAL = 16'h800D
) (
   input  logic            clk,
   input  logic            rst,
   usb_crc_serial_if.slave bus
);
   localparam logic [WIDTH-1:0] POLY_W   = POLY[WIDTH-1:0];
   localparam logic [WIDTH-1:0] INIT_W   = INIT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] RES_W    = RESIDUAL[WIDTH-1:0];
   localparam int               CW       = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, CALC, SEND, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] crc_q, crc_d;
   logic [WIDTH-1:0] crc_next;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic             ok_q, ok_d;
   logic             fb;

   // Remainder after folding in this cycle's payload bit (unchanged on a stall)
   always_comb begin
      fb       = bus.s_in ^ crc_q[WIDTH-1];
      crc_next = crc_q;
      if (bus.bit_valid) begin
         crc_next = {crc_q[WIDTH-2:0], 1'b0} ^ (fb ? POLY_W : '0);
      end
   end

   // Packet sequencing; a start in any state preloads and begins a new packet
   always_comb begin
      state_d = state_q;
      crc_d   = crc_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      ok_d    = ok_q;
      if (bus.crc_start) begin
         state_d = CALC;
         crc_d   = INIT_W;
         mode_d  = bus.crc_mode;
         ok_d    = 1'b0;
      end else begin
         case (state_q)
            CALC: begin
               crc_d = crc_next;
               if (bus.crc_eop) begin
                  if (mode_q) begin
                     ok_d    = (crc_next == RES_W);
                     state_d = DONE;
                  end else begin
                     shift_d = ~crc_next;
                     cnt_d   = CNT_LOAD;
                     state_d = SEND;
                  end
               end
            end
            SEND: begin
               if (!bus.crc_out_stall) begin
                  shift_d = {shift_q[WIDTH-2:0], 1'b0};
                  cnt_d   = cnt_q - CNT_ONE;
                  if (cnt_q == CNT_ONE) begin
                     state_d = DONE;
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         crc_q   <= INIT_W;
         shift_q <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         crc_q   <= crc_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         ok_q    <= ok_d;
      end
   end

   assign bus.crc_ready     = (state_q == IDLE);
   assign bus.crc_out_valid = (state_q == SEND);
   assign bus.crc_out       = (state_q == SEND) ? shift_q[WIDTH-1] : 1'b0;
   assign bus.crc_done      = (state_q == DONE);
   assign bus.crc_ok        = ok_q;

`ifdef USB_CRC_PARALLEL_VAL_EN
   logic [WIDTH-1:0] val_q, val_d;

   // Capture the pre-complement remainder at eop, clear it on a new packet
   always_comb begin
      val_d = val_q;
      if (bus.crc_start) begin
         val_d = '0;
      end else if (state_q == CALC && bus.crc_eop) begin
         val_d = crc_next;
      end
   end

   // Parallel remainder register
   always_ff @(posedge clk) begin
      if (rst) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign bus.crc_val = val_q;
`else
   assign bus.crc_val = '0;
`endif
endmodule

// File: tb/tb_usb_crc_serial.sv
// tb_usb_crc_serial: drives a CRC16 and a CRC5 instance of usb_crc_serial with
// a shared stimulus stream and checks the selected instance against a
// polynomial long-division model of the CRC.
module tb_usb_crc_serial;
   localparam logic [15:0] P16 = 16'h8005, I16 = 16'hFFFF, R16 = 16'h800D;
   localparam logic [15:0] P5  = 16'h0005, I5  = 16'h001F, R5  = 16'h000C;
`ifdef USB_CRC_PARALLEL_VAL_EN
   localparam bit VAL_EN = 1'b1;
`else
   localparam bit VAL_EN = 1'b0;
`endif

   typedef struct {
      bit           is5;
      bit           md;
      int           len;
      logic [175:0] bits;
      int           sPos;
      int           sLen;
      int           oPos;
      int           oLen;
      logic [15:0]  expRem;
      bit           expOk;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tStart = 1'b0, tMode = 1'b0, tBv = 1'b0, tSin = 1'b0, tEop = 1'b0, tOStall = 1'b0;

   int checks = 0;
   int errors = 0;

   bit          selIs5;
   logic [15:0] rOut;
   int          rValid, rAcc, rDone, rEarly, rHeldErr;
   logic        rOk, rOkAfter, rReadyAfter, rTimeout;
   logic [15:0] rVal;

   usb_crc_serial_if #(.WIDTH(16)) if16 ();
   usb_crc_serial_if #(.WIDTH(5))  if5 ();

   assign if16.crc_start = tStart;   assign if5.crc_start = tStart;
   assign if16.crc_mode  = tMode;    assign if5.crc_mode  = tMode;
   assign if16.bit_valid = tBv;      assign if5.bit_valid = tBv;
   assign if16.s_in      = tSin;     assign if5.s_in      = tSin;
   assign if16.crc_eop   = tEop;     assign if5.crc_eop   = tEop;
   assign if16.crc_out_stall = tOStall;
   assign if5.crc_out_stall  = tOStall;

   usb_crc_serial #(.WIDTH(16), .POLY(P16), .INIT(I16), .RESIDUAL(R16)) dut16 (
      .clk(clk), .rst(rst), .bus(if16.slave));
   usb_crc_serial #(.WIDTH(5), .POLY(P5), .INIT(I5), .RESIDUAL(R5)) dut5 (
      .clk(clk), .rst(rst), .bus(if5.slave));

   always #5 clk = ~clk;

   // Remainder of (M(x)*x^w + INIT(x)*x^len) mod (x^w + POLY) by long division
   function automatic logic [15:0] modelRem(input int w, input logic [15:0] poly,
                                            input logic [15:0] init,
                                            input logic [175:0] msg, input int len);
      logic [191:0] work;
      logic [15:0]  rem;
      work = '0;
      for (int i = 0; i < len; i++) work[i] = msg[i];
      for (int i = 0; i < w; i++) work[i] = work[i] ^ init[w-1-i];
      for (int i = 0; i < len; i++)
         if (work[i])
            for (int j = 0; j < w; j++) work[i+1+j] = work[i+1+j] ^ poly[w-1-j];
      rem = '0;
      for (int j = 0; j < w; j++) rem[w-1-j] = work[len+j];
      return rem;
   endfunction

   function automatic int wOf(input bit is5);        return is5 ? 5 : 16;        endfunction
   function automatic logic [15:0] pOf(input bit is5); return is5 ? P5 : P16;    endfunction
   function automatic logic [15:0] iOf(input bit is5); return is5 ? I5 : I16;    endfunction
   function automatic logic [15:0] resOf(input bit is5); return is5 ? R5 : R16;  endfunction
   function automatic logic [15:0] maskOf(input bit is5); return is5 ? 16'h001F : 16'hFFFF; endfunction

   function automatic logic [15:0] remOf(input bit is5, input logic [175:0] msg, input int len);
      return modelRem(wOf(is5), pOf(is5), iOf(is5), msg, len);
   endfunction

   // Payload followed by the transmitted (complemented) CRC, MSB first
   function automatic logic [175:0] withCrc(input bit is5, input logic [175:0] msg, input int len);
      logic [15:0]  g;
      logic [175:0] r;
      g = ~remOf(is5, msg, len);
      r = msg;
      for (int j = 0; j < wOf(is5); j++) r[len+j] = g[wOf(is5)-1-j];
      return r;
   endfunction

   function automatic logic dDone();  return selIs5 ? if5.crc_done      : if16.crc_done;      endfunction
   function automatic logic dValid(); return selIs5 ? if5.crc_out_valid : if16.crc_out_valid; endfunction
   function automatic logic dOut();   return selIs5 ? if5.crc_out       : if16.crc_out;       endfunction
   function automatic logic dOk();    return selIs5 ? if5.crc_ok        : if16.crc_ok;        endfunction
   function automatic logic dReady(); return selIs5 ? if5.crc_ready     : if16.crc_ready;     endfunction
   function automatic logic [15:0] dVal();
      return selIs5 ? 16'(if5.crc_val) : if16.crc_val;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic st, input logic md, input logic bv,
                                input logic sin, input logic eop);
      tStart = st; tMode = md; tBv = bv; tSin = sin; tEop = eop;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One packet: start, payload with optional input stall, eop, then CRC drain
   task automatic runPacket(input vec_t v, input bit stopAtDone);
      int cyc, stallUsed;
      logic heldBit, prevStalled;
      selIs5 = v.is5;
      rOut = '0; rValid = 0; rAcc = 0; rDone = 0; rEarly = 0; rHeldErr = 0;
      rOk = 1'b0; rOkAfter = 1'b0; rReadyAfter = 1'b0; rTimeout = 1'b0; rVal = '0;
      applyStimulus(1'b1, v.md, 1'b0, 1'b0, 1'b0);
      tick();
      rEarly += int'(dDone());
      for (int i = 0; i < v.len; i++) begin
         if (i == v.sPos) begin
            for (int s = 0; s < v.sLen; s++) begin
               applyStimulus(1'b0, v.md, 1'b0, $urandom_range(0, 1), 1'b0);
               tick();
               rEarly += int'(dDone());
            end
         end
         applyStimulus(1'b0, v.md, 1'b1, v.bits[i], (i == v.len - 1));
         tick();
         if (i != v.len - 1) rEarly += int'(dDone());
      end
      if (v.len == 0) begin
         applyStimulus(1'b0, v.md, 1'b0, 1'b0, 1'b1);
         tick();
      end
      applyStimulus(1'b0, v.md, 1'b0, 1'b0, 1'b0);
      cyc = 0; stallUsed = 0; heldBit = 1'b0; prevStalled = 1'b0;
      while (!dDone() && cyc < 200) begin
         if (dValid()) begin
            rValid++;
            if (prevStalled && dOut() !== heldBit) rHeldErr++;
            if (rAcc == v.oPos && stallUsed < v.oLen) begin
               tOStall = 1'b1; stallUsed++; heldBit = dOut(); prevStalled = 1'b1;
            end else begin
               tOStall = 1'b0; prevStalled = 1'b0;
               rOut = {rOut[14:0], dOut()};
               rAcc++;
            end
         end else begin
            tOStall = 1'b0;
         end
         tick();
         cyc++;
      end
      tOStall = 1'b0;
      rTimeout = (cyc >= 200);
      rDone = int'(dDone());
      rOk = dOk();
      rVal = dVal();
      if (!stopAtDone) begin
         tick();
         rDone += int'(dDone());
         tick();
         rDone += int'(dDone());
         rOkAfter = dOk();
         rReadyAfter = dReady();
      end
   endtask

   // Standard set of comparisons for a completed packet
   task automatic checkPacket(input vec_t v, input string tag);
      checkOutput({tag, "_timeout"}, 32'(rTimeout), 32'd0);
      checkOutput({tag, "_early_done"}, 32'(rEarly), 32'd0);
      checkOutput({tag, "_done_pulses"}, 32'(rDone), 32'd1);
      checkOutput({tag, "_ready_after"}, 32'(rReadyAfter), 32'd1);
      checkOutput({tag, "_val"}, 32'(rVal), VAL_EN ? 32'(v.expRem) : 32'd0);
      if (!v.md) begin
         checkOutput({tag, "_crc_bits"}, 32'(rOut & maskOf(v.is5)), 32'(~v.expRem & maskOf(v.is5)));
         checkOutput({tag, "_accepted"}, 32'(rAcc), 32'(wOf(v.is5)));
         checkOutput({tag, "_valid_cycles"}, 32'(rValid), 32'(wOf(v.is5) + v.oLen));
         checkOutput({tag, "_held"}, 32'(rHeldErr), 32'd0);
      end else begin
         checkOutput({tag, "_ok"}, 32'(rOk), 32'(v.expOk));
         checkOutput({tag, "_ok_held"}, 32'(rOkAfter), 32'(v.expOk));
         checkOutput({tag, "_no_valid"}, 32'(rValid), 32'd0);
      end
   endtask

   vec_t vecs [8];
   vec_t rv;
   logic [175:0] d500;
   logic [7:0]   pb [2];

   initial begin
      // Payload 0xD5,0x00 sent LSB first
      pb[0] = 8'hD5; pb[1] = 8'h00;
      d500 = '0;
      for (int b = 0; b < 2; b++)
         for (int k = 0; k < 8; k++) d500[b*8+k] = pb[b][k];

      vecs[0] = '{0, 0, 0,  '0,   -1, 0, -1, 0, 16'hFFFF, 0};
      vecs[1] = '{1, 0, 1,  '0,   -1, 0, -1, 0, 16'h001B, 0};
      vecs[2] = '{0, 0, 16, d500, -1, 0, -1, 0, remOf(0, d500, 16), 0};
      vecs[3] = '{0, 0, 16, d500,  5, 3, -1, 0, remOf(0, d500, 16), 0};
      vecs[4] = '{0, 0, 16, d500, -1, 0,  4, 2, remOf(0, d500, 16), 0};
      vecs[5] = '{0, 1, 32, withCrc(0, d500, 16), 7, 2, -1, 0, 16'h0, 1};
      vecs[5].expRem = remOf(0, vecs[5].bits, 32);
      vecs[6] = vecs[5];
      vecs[6].bits[3] = ~vecs[6].bits[3];
      vecs[6].expOk = 0;
      vecs[6].expRem = remOf(0, vecs[6].bits, 32);
      vecs[7] = '{1, 0, 11, 176'h5A3, 4, 1, 2, 1, remOf(1, 176'h5A3, 11), 0};

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      checkOutput("reset_ready16", 32'(if16.crc_ready), 32'd1);
      checkOutput("reset_ready5", 32'(if5.crc_ready), 32'd1);
      checkOutput("reset_outs16", {if16.crc_out, if16.crc_out_valid, if16.crc_done, if16.crc_ok}, 32'd0);
      checkOutput("reset_val16", 32'(if16.crc_val), 32'd0);

      for (int i = 0; i < 8; i++) begin
         runPacket(vecs[i], 1'b0);
         checkPacket(vecs[i], $sformatf("vec%0d", i));
      end

      // Restart while the previous CRC is still being shifted out
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, d500[i], (i == 3));
         tick();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      checkOutput("restart_in_send", 32'(if16.crc_out_valid), 32'd1);
      runPacket(vecs[2], 1'b0);
      checkPacket(vecs[2], "restart");

      // Reset in the middle of a packet, after a passing check left crc_ok high
      runPacket(vecs[5], 1'b0);
      checkOutput("pre_reset_ok", 32'(if16.crc_ok), 32'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("rst_mid_ready", 32'(if16.crc_ready), 32'd1);
      checkOutput("rst_mid_outs", {if16.crc_out, if16.crc_out_valid, if16.crc_done, if16.crc_ok}, 32'd0);
      checkOutput("rst_mid_val", 32'(if16.crc_val), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("eop_in_idle_ignored", {if16.crc_ready, if16.crc_done, if16.crc_out_valid}, 32'b100);

      // Back-to-back packets: second start in the DONE cycle of the first
      runPacket(vecs[1], 1'b1);
      checkOutput("b2b_first_done", 32'(rDone), 32'd1);
      checkOutput("b2b_first_bits", 32'(rOut & 16'h001F), 32'h04);
      runPacket(vecs[7], 1'b0);
      checkPacket(vecs[7], "b2b_second");

      // Randomized packets against the long-division model
      for (int n = 0; n < 24; n++) begin
         logic [175:0] m;
         rv.is5 = $urandom_range(0, 1);
         rv.md  = $urandom_range(0, 1);
         m = '0;
         rv.len = $urandom_range(0, 32);
         for (int i = 0; i < rv.len; i++) m[i] = $urandom_range(0, 1);
         rv.sPos = (rv.len > 0) ? $urandom_range(0, rv.len - 1) : -1;
         rv.sLen = $urandom_range(0, 3);
         rv.oPos = $urandom_range(0, wOf(rv.is5) - 1);
         rv.oLen = rv.md ? 0 : $urandom_range(0, 3);
         if (rv.md) begin
            m = withCrc(rv.is5, m, rv.len);
            rv.len = rv.len + wOf(rv.is5);
            if ($urandom_range(0, 1) == 1) begin
               int f;
               f = $urandom_range(0, rv.len - 1);
               m[f] = ~m[f];
            end
         end
         rv.bits = m;
         rv.expRem = remOf(rv.is5, m, rv.len);
         rv.expOk = (rv.expRem == resOf(rv.is5));
         runPacket(rv, 1'b0);
         checkPacket(rv, $sformatf("rand%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
